// File: rtl/pixel_write_sink.sv
// Plot-request sink: queues (x,y,colour) pixels, drops off-screen ones, writes a 160x120 framebuffer
// and performs full-screen clears. Define PIXEL_SINK_STATS_EN to add write/drop counters.
module pixel_write_sink #(
  parameter int unsigned X_MAX      = 160,
  parameter int unsigned Y_MAX      = 120,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        plot_x,
  input  logic [6:0]        plot_y,
  input  logic [2:0]        plot_color,
  input  logic              plot_valid,
  output logic              plot_ready,
  input  logic              clear_req,
  input  logic [2:0]        clear_color,
  output logic              clear_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_data,
  output logic              mem_we,
`ifdef PIXEL_SINK_STATS_EN
  output logic [15:0]       stat_written,
  output logic [15:0]       stat_dropped,
`endif
  output logic              drop_pulse
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0]   CntFull = CntW'(FIFO_DEPTH);
  localparam logic [7:0]        XLim    = 8'(X_MAX);
  localparam logic [6:0]        YLim    = 7'(Y_MAX);
  localparam logic [ADDR_W-1:0] ClrLast = ADDR_W'(X_MAX * Y_MAX - 1);

  typedef enum logic [1:0] {StIdle, StStream, StDrain, StClear} state_e;
  state_e state_q, state_d;

  logic [7:0]      fifo_x [FIFO_DEPTH];
  logic [6:0]      fifo_y [FIFO_DEPTH];
  logic [2:0]      fifo_c [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            full, empty, accept, pop;

  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [2:0]        clr_color_q, clr_color_d;
  logic              clr_last;

  logic [7:0]        head_x;
  logic [6:0]        head_y;
  logic [2:0]        head_c;
  logic              on_screen, plot_wr, plot_drop;
  logic [ADDR_W-1:0] y_ext, pix_addr;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [2:0]        mem_data_q, mem_data_d;
  logic              mem_we_q, mem_we_d;
  logic              done_q, done_d;
  logic              drop_q, drop_d;

  // Readiness looks at current occupancy only; a same-cycle pop never frees a full slot.
  assign full       = (count_q == CntFull);
  assign empty      = (count_q == '0);
  assign plot_ready = !full && !reset && (state_q != StDrain);
  assign accept     = plot_valid && plot_ready;
  assign pop        = !empty && (state_q != StClear);
  assign count_d    = count_q + CntW'(accept) - CntW'(pop);

  assign head_x    = fifo_x[rd_ptr_q];
  assign head_y    = fifo_y[rd_ptr_q];
  assign head_c    = fifo_c[rd_ptr_q];
  assign on_screen = (head_x < XLim) && (head_y < YLim);
  assign plot_wr   = pop && on_screen;
  assign plot_drop = pop && !on_screen;
  // y*160 as shift-add
  assign y_ext     = ADDR_W'(head_y);
  assign pix_addr  = (y_ext << 7) + (y_ext << 5) + ADDR_W'(head_x);

  assign clr_last   = (clr_addr_q == ClrLast);
  assign clr_addr_d = (state_q == StClear) ? clr_addr_q + ADDR_W'(1) : '0;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    clr_color_d = clr_color_q;
    unique case (state_q)
      StIdle, StStream: begin
        if (clear_req) begin
          state_d     = StDrain;
          clr_color_d = clear_color;
        end else begin
          state_d = (count_d != '0) ? StStream : StIdle;
        end
      end
      StDrain: begin
        if (count_d == '0) state_d = StClear;
      end
      StClear: begin
        if (clr_last) state_d = (count_d != '0) ? StStream : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic (registered below)
  always_comb begin
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    done_d     = 1'b0;
    drop_d     = plot_drop;
    if (state_q == StClear) begin
      mem_we_d   = 1'b1;
      mem_addr_d = clr_addr_q;
      mem_data_d = clr_color_q;
      done_d     = clr_last;
    end else if (plot_wr) begin
      mem_we_d   = 1'b1;
      mem_addr_d = pix_addr;
      mem_data_d = head_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      clr_addr_q  <= '0;
      clr_color_q <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_we_q    <= 1'b0;
      done_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q     <= count_d;
      clr_addr_q  <= clr_addr_d;
      clr_color_q <= clr_color_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_we_q    <= mem_we_d;
      done_q      <= done_d;
      drop_q      <= drop_d;
    end
  end

  // FIFO storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_x[wr_ptr_q] <= plot_x;
      fifo_y[wr_ptr_q] <= plot_y;
      fifo_c[wr_ptr_q] <= plot_color;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_we     = mem_we_q;
  assign clear_done = done_q;
  assign drop_pulse = drop_q;

`ifdef PIXEL_SINK_STATS_EN
  logic [15:0] stat_written_q, stat_dropped_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_written_q <= '0;
      stat_dropped_q <= '0;
    end else begin
      if (plot_wr && (stat_written_q != 16'hFFFF)) stat_written_q <= stat_written_q + 16'd1;
      if (plot_drop && (stat_dropped_q != 16'hFFFF)) stat_dropped_q <= stat_dropped_q + 16'd1;
    end
  end

  assign stat_written = stat_written_q;
  assign stat_dropped = stat_dropped_q;
`endif

endmodule

// File: tb/tb_pixel_write_sink.sv
// Directed bench for pixel_write_sink: plot latency, clipping, clear sequencing, reset abort.
module tb_pixel_write_sink;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  plot_x = '0;
  logic [6:0]  plot_y = '0;
  logic [2:0]  plot_color = '0;
  logic        plot_valid = 1'b0;
  logic        plot_ready;
  logic        clear_req = 1'b0;
  logic [2:0]  clear_color = '0;
  logic        clear_done;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_we;
  logic        drop_pulse;
`ifdef PIXEL_SINK_STATS_EN
  logic [15:0] stat_written, stat_dropped;
`endif

  pixel_write_sink dut (
    .clk         (clk),
    .reset       (reset),
    .plot_x      (plot_x),
    .plot_y      (plot_y),
    .plot_color  (plot_color),
    .plot_valid  (plot_valid),
    .plot_ready  (plot_ready),
    .clear_req   (clear_req),
    .clear_color (clear_color),
    .clear_done  (clear_done),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_we      (mem_we),
`ifdef PIXEL_SINK_STATS_EN
    .stat_written(stat_written),
    .stat_dropped(stat_dropped),
`endif
    .drop_pulse  (drop_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [14:0] addr;
    logic [2:0]  data;
  } wr_t;

  wr_t         wr_q[$];
  int          drop_cnt = 0;
  int          done_cnt = 0;
  logic [14:0] done_addr = '0;
  logic        done_we = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) wr_q.push_back('{addr: mem_addr, data: mem_data});
      if (drop_pulse) drop_cnt++;
      if (clear_done) begin
        done_cnt++;
        done_addr = mem_addr;
        done_we   = mem_we;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Entered and left 1 time unit after a rising edge.
  task automatic plot(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    int n = 0;
    plot_x = x; plot_y = y; plot_color = c; plot_valid = 1'b1;
    @(negedge clk);
    while (!plot_ready && n < 30000) begin
      @(negedge clk);
      n++;
    end
    if (!plot_ready) check("plot_ready_timeout", {31'd0, plot_ready}, 32'd1);
    @(posedge clk);
    #1 plot_valid = 1'b0;
  endtask

  task automatic single_plot_check();
    plot(8'd10, 7'd5, 3'b111);
    @(negedge clk);
    check("s2_no_early_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    check("s2_we", {31'd0, mem_we}, 32'd1);
    check("s2_addr", {17'd0, mem_addr}, 32'd810);
    check("s2_data", {29'd0, mem_data}, 32'd7);
    @(negedge clk);
    check("s2_single_cycle", {31'd0, mem_we}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w0, d0, dn0, n, bad, acc, acc_at_done, go;
    logic ready_at_done;

    // Reset state
    #12;
    check("rst_ready", {31'd0, plot_ready}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", {17'd0, mem_addr}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {31'd0, plot_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Single plot latency and address
    single_plot_check();

    // Clipping and maximum address
    d0 = drop_cnt;
    w0 = wr_q.size();
    plot(8'd160, 7'd0, 3'd1);
    plot(8'd0, 7'd120, 3'd2);
    plot(8'd159, 7'd119, 3'd5);
    idle(5);
    check("s3_drops", drop_cnt - d0, 32'd2);
    check("s3_writes", wr_q.size() - w0, 32'd1);
    check("s3_max_addr", {17'd0, wr_q[w0].addr}, 32'd19199);
    check("s3_max_data", {29'd0, wr_q[w0].data}, 32'd5);

    // Reset mid-stream
    plot(8'd1, 7'd1, 3'd1);
    plot(8'd2, 7'd1, 3'd2);
    check("s1_mid_stream", {31'd0, mem_we}, 32'd1);
    reset = 1'b1;
    #1;
    check("s1_we", {31'd0, mem_we}, 32'd0);
    check("s1_addr", {17'd0, mem_addr}, 32'd0);
    check("s1_data", {29'd0, mem_data}, 32'd0);
    check("s1_ready", {31'd0, plot_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    w0 = wr_q.size();
    #1;
    check("s1_ready_release", {31'd0, plot_ready}, 32'd1);
    idle(4);
    check("s1_fifo_empty", wr_q.size() - w0, 32'd0);

    // Clear with two pixels ahead of it
    w0  = wr_q.size();
    dn0 = done_cnt;
    plot(8'd20, 7'd3, 3'd1);
    plot_x = 8'd21; plot_y = 7'd3; plot_color = 3'd2; plot_valid = 1'b1;
    clear_req = 1'b1; clear_color = 3'b101;
    @(negedge clk);
    check("s4_ready", {31'd0, plot_ready}, 32'd1);
    @(posedge clk);
    #1 plot_valid = 1'b0; clear_req = 1'b0;
    n = 0;
    while (done_cnt == dn0 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    idle(3);
    check("s4_writes", wr_q.size() - w0, 32'd19202);
    check("s4_p0_addr", {17'd0, wr_q[w0].addr}, 32'd500);
    check("s4_p0_data", {29'd0, wr_q[w0].data}, 32'd1);
    check("s4_p1_addr", {17'd0, wr_q[w0+1].addr}, 32'd501);
    check("s4_p1_data", {29'd0, wr_q[w0+1].data}, 32'd2);
    bad = 0;
    for (int i = 0; i < 19200; i++) begin
      if (w0 + 2 + i >= wr_q.size()) bad++;
      else if (wr_q[w0+2+i].addr != 15'(i) || wr_q[w0+2+i].data != 3'b101) bad++;
    end
    check("s4_clear_seq_bad", bad, 32'd0);
    check("s4_done_count", done_cnt - dn0, 32'd1);
    check("s4_done_addr", {17'd0, done_addr}, 32'd19199);
    check("s4_done_we", {31'd0, done_we}, 32'd1);

    // Plots held off by a clear
    w0  = wr_q.size();
    dn0 = done_cnt;
    clear_req = 1'b1; clear_color = 3'd2;
    @(posedge clk);
    #1 clear_req = 1'b0;
    acc = 0; acc_at_done = -1; ready_at_done = 1'b1; n = 0;
    while (acc < 6 && n < 25000) begin
      plot_x = 8'(acc * 3); plot_y = 7'(acc + 1); plot_color = 3'(acc + 1); plot_valid = 1'b1;
      @(negedge clk);
      if (clear_done) begin
        acc_at_done   = acc;
        ready_at_done = plot_ready;
      end
      go = int'(plot_ready);
      @(posedge clk);
      #1;
      if (go != 0) acc++;
      n++;
    end
    plot_valid = 1'b0;
    idle(10);
    check("s5_accepted_total", acc, 32'd6);
    check("s5_accepted_in_clear", acc_at_done, 32'd4);
    check("s5_ready_at_done", {31'd0, ready_at_done}, 32'd0);
    check("s5_done_count", done_cnt - dn0, 32'd1);
    check("s5_writes", wr_q.size() - w0, 32'd19206);
    bad = 0;
    for (int i = 0; i < 19200; i++) begin
      if (w0 + i >= wr_q.size()) bad++;
      else if (wr_q[w0+i].addr != 15'(i) || wr_q[w0+i].data != 3'd2) bad++;
    end
    check("s5_clear_seq_bad", bad, 32'd0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (w0 + 19200 + i >= wr_q.size()) bad++;
      else if (wr_q[w0+19200+i].addr != 15'((i + 1) * 160 + 3 * i) ||
               wr_q[w0+19200+i].data != 3'(i + 1)) bad++;
    end
    check("s5_pixel_order_bad", bad, 32'd0);

    // Reset during clear
    dn0 = done_cnt;
    clear_req = 1'b1; clear_color = 3'd6;
    @(posedge clk);
    #1 clear_req = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(mem_we && mem_addr == 15'd5000) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("s6_reached_5000", {17'd0, mem_addr}, 32'd5000);
    #1 reset = 1'b1;
    #1;
    check("s6_we", {31'd0, mem_we}, 32'd0);
    check("s6_done", {31'd0, clear_done}, 32'd0);
    check("s6_addr", {17'd0, mem_addr}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    w0 = wr_q.size();
    idle(5);
    check("s6_no_done", done_cnt - dn0, 32'd0);
    check("s6_no_writes", wr_q.size() - w0, 32'd0);
    single_plot_check();
`ifdef PIXEL_SINK_STATS_EN
    check("stat_written", {16'd0, stat_written}, 32'd1);
    check("stat_dropped", {16'd0, stat_dropped}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
